ahb_master_arbiter: RTL and testbench

//  Shares one AHB-lite slave-side bus between NUM_MASTERS masters. Round-robin grant with a
//  per-owner burst-hold limit; muxes address/control by address-phase owner and HWDATA by

---
 rtl/ahb_lite_pkg.sv | 14 +
 rtl/ahb_rr_pick.sv | 28 ++
 rtl/ahb_master_arbiter.sv | 127 ++++++++++++
 tb/tb_ahb_master_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// AHB-lite shared encodings used by the master arbiter and its users.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef logic [2:0] hsize_t;

   localparam hsize_t HSIZE_BYTE  = 3'b000;
   localparam hsize_t HSIZE_HALF  = 3'b001;
   localparam hsize_t HSIZE_WORD  = 3'b010;
   localparam hsize_t HSIZE_DWORD = 3'b011;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning start, start+1, ... mod N.
module ahb_rr_pick #(
   parameter  int unsigned N  = 4,
   localparam int unsigned MW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [MW-1:0] start,
   output logic [MW-1:0] id,
   output logic          valid
);

   int unsigned idx;

   // Scan from start with wrap; the first hit wins.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (32'(start) + 32'(i)) % N;
         if (!valid && req[MW'(idx)]) begin
            valid = 1'b1;
            id    = MW'(idx);
         end
      end
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-lite master arbiter with per-tenure hold limit.
// Optional bus locking is compiled in with AHB_ARB_LOCK_EN.
module ahb_master_arbiter
   import ahb_lite_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS = 4,
   parameter  int unsigned MAX_HOLD    = 4,
   localparam int unsigned MW          = $clog2(NUM_MASTERS)
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [NUM_MASTERS-1:0]    HBUSREQ,
   input  logic [NUM_MASTERS*32-1:0] HADDR_M,
   input  logic [NUM_MASTERS*2-1:0]  HTRANS_M,
   input  logic [NUM_MASTERS-1:0]    HWRITE_M,
   input  logic [NUM_MASTERS*3-1:0]  HSIZE_M,
   input  logic [NUM_MASTERS*32-1:0] HWDATA_M,
   input  logic [NUM_MASTERS-1:0]    HMASTLOCK_M,
   input  logic                      HREADY,
   output logic [NUM_MASTERS-1:0]    HGRANT,
   output logic [MW-1:0]             HMASTER,
   output logic [MW-1:0]             HMASTER_D,
   output logic [31:0]               HADDR,
   output logic [1:0]                HTRANS,
   output logic                      HWRITE,
   output hsize_t                    HSIZE,
   output logic [31:0]               HWDATA,
   output logic                      HMASTLOCK
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);

   logic [MW-1:0]          owner_q, owner_n;
   logic [MW-1:0]          owner_d_q, owner_d_n;
   logic [HW-1:0]          hold_q, hold_n, hold_inc;
   logic [NUM_MASTERS-1:0] grant_q, grant_n;
   logic [NUM_MASTERS-1:0] others;
   logic [MW-1:0]          pick_start, pick_id;
   logic                   pick_valid;
   logic                   accepted, lock_keep, keep;

   assign others     = HBUSREQ & ~grant_q;
   assign pick_start = (owner_q == MW'(NUM_MASTERS - 1)) ? '0 : owner_q + MW'(1);
   assign accepted   = HTRANS[1];

`ifdef AHB_ARB_LOCK_EN
   assign lock_keep = accepted & HMASTLOCK;
`else
   logic unused_lock;
   assign lock_keep   = 1'b0;
   assign unused_lock = ^HMASTLOCK_M;
`endif

   ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
      .req   (others),
      .start (pick_start),
      .id    (pick_id),
      .valid (pick_valid)
   );

   // Owner, data-phase owner, hold count and grant registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         owner_q   <= '0;
         owner_d_q <= '0;
         hold_q    <= '0;
         grant_q   <= NUM_MASTERS'(1);
      end else begin
         owner_q   <= owner_n;
         owner_d_q <= owner_d_n;
         hold_q    <= hold_n;
         grant_q   <= grant_n;
      end
   end

   // Next-state arbitration; everything holds while HREADY is low.
   always_comb begin
      owner_n   = owner_q;
      owner_d_n = owner_d_q;
      hold_n    = hold_q;
      grant_n   = grant_q;
      hold_inc  = hold_q;
      keep      = 1'b0;
      if (HREADY) begin
         owner_d_n = owner_q;
         if (accepted && (hold_q != HW'(MAX_HOLD)))
            hold_inc = hold_q + HW'(1);
         keep = lock_keep ||
                (HBUSREQ[owner_q] && ((others == '0) || (hold_inc < HW'(MAX_HOLD))));
         if (!keep && pick_valid) begin
            owner_n = pick_id;
            hold_n  = '0;
         end else begin
            hold_n  = hold_inc;
         end
         grant_n = NUM_MASTERS'(1) << owner_n;
      end
   end

   // Address/control muxed by address owner, write data by data-phase owner.
   always_comb begin
      HADDR     = '0;
      HTRANS    = HTRANS_IDLE;
      HWRITE    = 1'b0;
      HSIZE     = HSIZE_BYTE;
      HWDATA    = '0;
      HMASTLOCK = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (owner_q == MW'(i)) begin
            HADDR  = HADDR_M[32*i +: 32];
            HTRANS = HTRANS_M[2*i +: 2];
            HWRITE = HWRITE_M[i];
            HSIZE  = HSIZE_M[3*i +: 3];
`ifdef AHB_ARB_LOCK_EN
            HMASTLOCK = HMASTLOCK_M[i];
`endif
         end
         if (owner_d_q == MW'(i))
            HWDATA = HWDATA_M[32*i +: 32];
      end
   end

   assign HGRANT    = grant_q;
   assign HMASTER   = owner_q;
   assign HMASTER_D = owner_d_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter (4 masters, MAX_HOLD 4).
module tb_ahb_master_arbiter;
   import ahb_lite_pkg::*;

   logic         HCLK;
   logic         HRESET;
   logic [3:0]   HBUSREQ;
   logic [127:0] HADDR_M;
   logic [7:0]   HTRANS_M;
   logic [3:0]   HWRITE_M;
   logic [11:0]  HSIZE_M;
   logic [127:0] HWDATA_M;
   logic [3:0]   HMASTLOCK_M;
   logic         HREADY;
   logic [3:0]   HGRANT;
   logic [1:0]   HMASTER;
   logic [1:0]   HMASTER_D;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic         HWRITE;
   hsize_t       HSIZE;
   logic [31:0]  HWDATA;
   logic         HMASTLOCK;

   ahb_master_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(4)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HBUSREQ     (HBUSREQ),
      .HADDR_M     (HADDR_M),
      .HTRANS_M    (HTRANS_M),
      .HWRITE_M    (HWRITE_M),
      .HSIZE_M     (HSIZE_M),
      .HWDATA_M    (HWDATA_M),
      .HMASTLOCK_M (HMASTLOCK_M),
      .HREADY      (HREADY),
      .HGRANT      (HGRANT),
      .HMASTER     (HMASTER),
      .HMASTER_D   (HMASTER_D),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HWDATA      (HWDATA),
      .HMASTLOCK   (HMASTLOCK)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [3:0] req;
      logic [3:0] ns;
      logic       rdy;
      logic [1:0] own;
      logic [1:0] down;
   } vec_t;

   typedef struct {
      logic [1:0] own;
      logic [1:0] down;
      logic [1:0] trans;
      logic       lock;
   } exp_t;

   exp_t       sb[$];
   vec_t       tbl[22];
   int         total = 0;
   int         bad   = 0;
   logic [3:0] wr_pat = 4'b0101;

   function automatic logic [31:0] addr_of(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h100;
   endfunction

   function automatic logic [31:0] data_of(input int i);
      return 32'hD00D_0000 | 32'(i);
   endfunction

   function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endfunction

   // Pop one expectation and compare every observable output against it.
   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty t=%0t got=0 want=1", $time);
      end else begin
         e = sb.pop_front();
         chk("hmaster",   32'(HMASTER),   32'(e.own));
         chk("hmaster_d", 32'(HMASTER_D), 32'(e.down));
         chk("hgrant",    32'(HGRANT),    32'(4'b0001 << e.own));
         chk("haddr",     HADDR,          addr_of(int'(e.own)));
         chk("htrans",    32'(HTRANS),    32'(e.trans));
         chk("hwrite",    32'(HWRITE),    32'(wr_pat[e.own]));
         chk("hsize",     32'(HSIZE),     32'(e.own));
         chk("hwdata",    HWDATA,         data_of(int'(e.down)));
         chk("hmastlock", 32'(HMASTLOCK), 32'(e.lock));
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge state, then compare.
   task automatic step(input logic [3:0] req, input logic [3:0] ns, input logic [3:0] lk,
                       input logic rdy, input logic rst,
                       input logic [1:0] eown, input logic [1:0] edown);
      exp_t e;
      HBUSREQ     = req;
      HREADY      = rdy;
      HRESET      = rst;
      HMASTLOCK_M = lk;
      for (int i = 0; i < 4; i++)
         HTRANS_M[2*i +: 2] = ns[i] ? HTRANS_NONSEQ : HTRANS_IDLE;
      e.own   = eown;
      e.down  = edown;
      e.trans = ns[eown] ? HTRANS_NONSEQ : HTRANS_IDLE;
`ifdef AHB_ARB_LOCK_EN
      e.lock  = lk[eown];
`else
      e.lock  = 1'b0;
`endif
      sb.push_back(e);
      @(posedge HCLK);
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] eo, prev;

      //               req      ns       rdy   own   down
      tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 2'd0};
      tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 2'd2, 2'd0};
      tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[5]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[7]  = '{4'b0110, 4'b0100, 1'b1, 2'd1, 2'd2};
      tbl[8]  = '{4'b0110, 4'b0010, 1'b1, 2'd1, 2'd1};
      tbl[9]  = '{4'b0110, 4'b0010, 1'b0, 2'd1, 2'd1};
      tbl[10] = '{4'b0110, 4'b0010, 1'b0, 2'd1, 2'd1};
      tbl[11] = '{4'b0110, 4'b0010, 1'b0, 2'd1, 2'd1};
      tbl[12] = '{4'b0110, 4'b0010, 1'b1, 2'd1, 2'd1};
      tbl[13] = '{4'b0110, 4'b0010, 1'b1, 2'd1, 2'd1};
      tbl[14] = '{4'b0110, 4'b0010, 1'b1, 2'd2, 2'd1};
      tbl[15] = '{4'b0110, 4'b0100, 1'b1, 2'd2, 2'd2};
      tbl[16] = '{4'b0010, 4'b0000, 1'b1, 2'd1, 2'd2};
      tbl[17] = '{4'b0010, 4'b0000, 1'b1, 2'd1, 2'd1};
      tbl[18] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 2'd1};
      tbl[19] = '{4'b1001, 4'b0000, 1'b1, 2'd3, 2'd1};
      tbl[20] = '{4'b1001, 4'b1000, 1'b1, 2'd3, 2'd3};
      tbl[21] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 2'd3};

      HWRITE_M = wr_pat;
      for (int i = 0; i < 4; i++) begin
         HADDR_M[32*i +: 32]  = addr_of(i);
         HWDATA_M[32*i +: 32] = data_of(i);
         HSIZE_M[3*i +: 3]    = 3'(i);
      end

      // Reset with no requests: master 0 parked.
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0);

      // Grant, hold saturation, HREADY stall, drop/raise and wrap.
      for (int v = 0; v < 22; v++)
         step(tbl[v].req, tbl[v].ns, 4'b0000, tbl[v].rdy, 1'b0, tbl[v].own, tbl[v].down);

      // Masters 0 and 3 both streaming: four accepted transfers per tenure.
      prev = 2'd0;
      for (int k = 1; k <= 12; k++) begin
         eo = (((k / 4) % 2) != 0) ? 2'd3 : 2'd0;
         step(4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0, eo, prev);
         prev = eo;
      end

      // Master 3 mid-burst, then synchronous reset during traffic.
      step(4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0, 2'd3, 2'd3);
      step(4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0);

      // Master 0 locked and streaming while master 1 requests.
      for (int k = 1; k <= 10; k++) begin
`ifdef AHB_ARB_LOCK_EN
         step(4'b0011, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0);
`else
         step(4'b0011, 4'b0001, 4'b0001, 1'b1, 1'b0,
              (k >= 4) ? 2'd1 : 2'd0, (k >= 5) ? 2'd1 : 2'd0);
`endif
      end

      // Lock released: master 1 owns the bus.
`ifdef AHB_ARB_LOCK_EN
      step(4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 2'd0);
`else
      step(4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 2'd1);
`endif

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
